mips_program_loader: RTL and testbench

MIPS_PROGRAM_LOADER -- requirements
Module: mips_program_loader

---
 rtl/mips_program_loader.sv | 162 ++++++++++++++++
 tb/tb_mips_program_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_program_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mips_program_loader
//
// Loads a program into instruction memory from a byte stream, holding the CPU
// core in reset until the load completes.
//
// Stream format: one header byte H (word count minus one, so 1..256 words),
// followed by 4*(H+1) bytes, each word sent MSB first. Each assembled word is
// written in a single-cycle strobe at byte address word_index*4. If the stream
// stalls inside a load for timeout_cycles cycles, the load is abandoned,
// load_err is raised, and the loader waits for a new header.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   byte_in      : program byte
//   byte_valid   : byte_in is valid
//   byte_ready   : loader accepts byte_in this cycle
//   reload       : single-cycle request for a new load (honoured only in DONE)
//   im_wr_en     : instruction memory write strobe
//   im_wr_add    : instruction memory byte address (word index * 4)
//   im_wr_data   : assembled instruction word
//   cpu_rst      : active-low core hold; high only while the program is loaded
//   load_done    : program loaded and core running
//   load_err     : last load aborted on timeout (sticky until next header)
//   words_loaded : words written in the current or last load
// -----------------------------------------------------------------------------
module mips_program_loader #(
    parameter int Ins_mem_width  = 32,
    parameter int Ins_mem_depth  = 256,
    parameter int timeout_cycles = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    input  logic                     reload,
    output logic                     im_wr_en,
    output logic [31:0]              im_wr_add,
    output logic [Ins_mem_width-1:0] im_wr_data,
    output logic                     cpu_rst,
    output logic                     load_done,
    output logic                     load_err,
    output logic [8:0]               words_loaded
);

    localparam logic [2:0] HEADER = 3'd0;
    localparam logic [2:0] DATA   = 3'd1;
    localparam logic [2:0] WRITE  = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
    localparam logic [2:0] ERROR  = 3'd4;

    localparam int BYTES_PER_WORD = Ins_mem_width / 8;
    localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    localparam int IDLE_W = $clog2(timeout_cycles + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(timeout_cycles - 1);

    // The header can request up to 256 words; never exceed the memory depth.
    localparam int         MAX_WORDS   = (Ins_mem_depth < 256) ? Ins_mem_depth : 256;
    localparam logic [8:0] MAX_WORDS_9 = 9'(MAX_WORDS);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [8:0]        target;
    logic [IDX_W-1:0]  byte_idx;
    logic [IDLE_W-1:0] idle_cnt;
    logic              accept;
    logic [8:0]        hdr_count;
    logic              write_last;

    assign byte_ready = (state == HEADER) || (state == DATA);
    assign accept     = byte_valid && byte_ready;
    assign im_wr_en   = (state == WRITE);
    // Only words 0..255 are ever written, so bits above [9:2] stay zero.
    assign im_wr_add  = {22'd0, words_loaded[7:0], 2'b00};
    assign hdr_count  = {1'b0, byte_in} + 9'd1;
    assign write_last = ((words_loaded + 9'd1) == target);

    always_comb begin
        // NOTE: every branch below may leave state_next untouched; the default
        // assignment first keeps this purely combinational (no latch).
        state_next = state;
        unique case (state)
            HEADER: if (accept) state_next = DATA;
            DATA: begin
                if (accept) begin
                    if (byte_idx == LAST_IDX) state_next = WRITE;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_next = ERROR;
                end
            end
            WRITE:   state_next = write_last ? DONE : DATA;
            DONE:    if (reload) state_next = HEADER;
            ERROR:   state_next = HEADER;
            default: state_next = HEADER;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= HEADER;
            target       <= 9'd0;
            words_loaded <= 9'd0;
            byte_idx     <= '0;
            idle_cnt     <= '0;
            im_wr_data   <= '0;
            cpu_rst      <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            state <= state_next;
            // Registered so both rise together on the first DONE cycle and
            // both fall on the cycle HEADER is re-entered.
            cpu_rst   <= (state_next == DONE);
            load_done <= (state_next == DONE);

            unique case (state)
                HEADER: begin
                    if (accept) begin
                        target       <= (hdr_count > MAX_WORDS_9) ? MAX_WORDS_9 : hdr_count;
                        words_loaded <= 9'd0;
                        byte_idx     <= '0;
                        idle_cnt     <= '0;
                        load_err     <= 1'b0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        // MSB first: earlier bytes shift toward the top.
                        im_wr_data <= (im_wr_data << 8) | Ins_mem_width'(byte_in);
                        byte_idx   <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
                        idle_cnt   <= '0;
                    end else if (state_next == ERROR) begin
                        // The partial word is dropped: WRITE is never visited.
                        load_err <= 1'b1;
                        idle_cnt <= '0;
                        byte_idx <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    words_loaded <= words_loaded + 9'd1;
                    byte_idx     <= '0;
                    idle_cnt     <= '0;
                end
                ERROR: begin
                    byte_idx <= '0;
                    idle_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_program_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mips_program_loader
//
// Directed bench for mips_program_loader. The stimulus thread pushes every
// write it expects onto exp_q before sending the bytes; an independent
// monitor pops and compares on each im_wr_en pulse. Outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_mips_program_loader;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        reload = 1'b0;
    logic        byte_ready;
    logic        im_wr_en;
    logic [31:0] im_wr_add;
    logic [31:0] im_wr_data;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;
    logic [8:0]  words_loaded;

    mips_program_loader #(
        .Ins_mem_width (32),
        .Ins_mem_depth (256),
        .timeout_cycles(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .reload      (reload),
        .im_wr_en    (im_wr_en),
        .im_wr_add   (im_wr_add),
        .im_wr_data  (im_wr_data),
        .cpu_rst     (cpu_rst),
        .load_done   (load_done),
        .load_err    (load_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] add;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (im_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got add 0x%0h data 0x%0h, expected no write",
                         im_wr_add, im_wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_add", 64'(im_wr_add), 64'(e.add));
                check("wr_data", 64'(im_wr_data), 64'(e.data));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within 5 ms");
        $fatal(1, "watchdog");
    end

    task automatic push_wr(input logic [31:0] add, input logic [31:0] data);
        wr_t e;
        e.add  = add;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Called on a falling edge. Holds the byte until the DUT shows ready, then
    // lets one rising edge take it; returns on the following falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output int waited);
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        waited     = 0;
        while (byte_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            total++;
            bad++;
            $display("FAIL byte_accept_timeout: got byte_ready=0 for 100 cycles, expected 1");
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int wt;
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], 0, wt);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    initial begin
        int          wt;
        logic [7:0]  i8;
        logic [31:0] w;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check("rst_im_wr_en", 64'(im_wr_en), 64'd0);
        check("rst_im_wr_add", 64'(im_wr_add), 64'd0);
        check("rst_im_wr_data", 64'(im_wr_data), 64'd0);
        check("rst_cpu_rst", 64'(cpu_rst), 64'd0);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_load_err", 64'(load_err), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_byte_ready", 64'(byte_ready), 64'd1);

        // ---------------- two-word load, valid held through WRITE ----------------
        push_wr(32'h0, 32'h8C08_0004);
        push_wr(32'h4, 32'h2009_0005);
        send_byte(8'h01, 0, wt);
        check("hdr_cpu_rst_low", 64'(cpu_rst), 64'd0);
        send_byte(8'h8C, 0, wt);
        send_byte(8'h08, 0, wt);
        send_byte(8'h00, 0, wt);
        send_byte(8'h04, 0, wt);
        check("write_ready_low", 64'(byte_ready), 64'd0);
        check("write_en_high", 64'(im_wr_en), 64'd1);
        send_byte(8'h20, 0, wt);
        check("fifth_byte_wait", 64'(wt), 64'd1);
        send_byte(8'h09, 0, wt);
        check("sixth_byte_wait", 64'(wt), 64'd0);
        send_byte(8'h00, 0, wt);
        send_byte(8'h05, 0, wt);
        check("last_write_cpu_rst", 64'(cpu_rst), 64'd0);
        @(negedge clk);
        check("t1_load_done", 64'(load_done), 64'd1);
        check("t1_cpu_rst", 64'(cpu_rst), 64'd1);
        check("t1_words", 64'(words_loaded), 64'd2);
        check("t1_done_ready", 64'(byte_ready), 64'd0);
        // Bytes offered in DONE must be ignored.
        byte_in    = 8'h77;
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        check("done_words_hold", 64'(words_loaded), 64'd2);

        // ---------------- reload from DONE, reload ignored in DATA ----------------
        pulse_reload();
        check("reload_cpu_rst", 64'(cpu_rst), 64'd0);
        check("reload_load_done", 64'(load_done), 64'd0);
        check("reload_ready", 64'(byte_ready), 64'd1);
        push_wr(32'h0, 32'h1122_3344);
        send_byte(8'h00, 0, wt);
        send_byte(8'h11, 0, wt);
        send_byte(8'h22, 0, wt);
        pulse_reload();
        check("data_reload_ready", 64'(byte_ready), 64'd1);
        check("data_reload_words", 64'(words_loaded), 64'd0);
        send_byte(8'h33, 0, wt);
        send_byte(8'h44, 0, wt);
        check("t2_write_en", 64'(im_wr_en), 64'd1);
        check("t2_write_cpu_rst", 64'(cpu_rst), 64'd0);
        @(negedge clk);
        check("t2_cpu_rst", 64'(cpu_rst), 64'd1);
        check("t2_load_done", 64'(load_done), 64'd1);
        check("t2_words", 64'(words_loaded), 64'd1);

        // ---------------- timeout inside a word ----------------
        pulse_reload();
        send_byte(8'h00, 0, wt);
        send_byte(8'hAA, 0, wt);
        send_byte(8'hBB, 0, wt);
        repeat (TO - 1) @(negedge clk);
        check("to_edge_ready", 64'(byte_ready), 64'd1);
        check("to_edge_err", 64'(load_err), 64'd0);
        @(negedge clk);
        check("err_ready", 64'(byte_ready), 64'd0);
        check("err_load_err", 64'(load_err), 64'd1);
        check("err_cpu_rst", 64'(cpu_rst), 64'd0);
        check("err_load_done", 64'(load_done), 64'd0);
        check("err_words", 64'(words_loaded), 64'd0);
        @(negedge clk);
        check("post_err_ready", 64'(byte_ready), 64'd1);
        check("post_err_sticky", 64'(load_err), 64'd1);
        push_wr(32'h0, 32'hDEAD_BEEF);
        send_byte(8'h00, 0, wt);
        check("hdr_clears_err", 64'(load_err), 64'd0);
        send_word(32'hDEAD_BEEF);
        @(negedge clk);
        check("t3_load_done", 64'(load_done), 64'd1);

        // ---------------- full 256-word load with gaps ----------------
        pulse_reload();
        send_byte(8'hFF, 0, wt);
        for (int i = 0; i < 256; i++) begin
            i8 = 8'(i);
            w  = {i8, ~i8, 8'hA5, i8 ^ 8'h3C};
            push_wr(32'(i) * 32'd4, w);
            for (int k = 3; k >= 0; k--)
                send_byte(w[8*k +: 8], int'($urandom_range(0, TO - 1)), wt);
        end
        @(negedge clk);
        check("full_load_done", 64'(load_done), 64'd1);
        check("full_cpu_rst", 64'(cpu_rst), 64'd1);
        check("full_words", 64'(words_loaded), 64'd256);

        // ---------------- reset in the middle of word 3 ----------------
        pulse_reload();
        push_wr(32'h0, 32'h0102_0304);
        push_wr(32'h4, 32'h0506_0708);
        send_byte(8'h03, 0, wt);
        send_word(32'h0102_0304);
        send_word(32'h0506_0708);
        send_byte(8'h09, 0, wt);
        send_byte(8'h0A, 0, wt);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_ready", 64'(byte_ready), 64'd1);
        check("mid_rst_wr_en", 64'(im_wr_en), 64'd0);
        check("mid_rst_add", 64'(im_wr_add), 64'd0);
        check("mid_rst_data", 64'(im_wr_data), 64'd0);
        check("mid_rst_cpu_rst", 64'(cpu_rst), 64'd0);
        check("mid_rst_done", 64'(load_done), 64'd0);
        check("mid_rst_err", 64'(load_err), 64'd0);
        check("mid_rst_words", 64'(words_loaded), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_wr(32'h0, 32'hCAFE_F00D);
        push_wr(32'h4, 32'h1234_5678);
        send_byte(8'h01, 0, wt);
        send_word(32'hCAFE_F00D);
        send_word(32'h1234_5678);
        @(negedge clk);
        check("post_rst_done", 64'(load_done), 64'd1);
        check("post_rst_words", 64'(words_loaded), 64'd2);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
